// File: rtl/param_proc.sv
// param_proc: parametrised multicycle core on a shared req/ready memory port.
// Optional memory-wait timeout enabled by defining PARAM_PROC_WAIT_TIMEOUT_EN.
module param_proc #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int RSEL_W  = 3,
   parameter int TIMEOUT = 16
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Run,
   input  logic [DATA_W-1:0] DIN,
   input  logic              MemReady,
   output logic              MemReq,
   output logic              W,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] DOUT,
   output logic              Done,
   output logic              Zero,
   output logic              Carry,
   output logic              Fault
);

   localparam int NREG = 2 ** RSEL_W;
   localparam int IW   = 3 + 2 * RSEL_W;
   localparam int PC   = NREG - 1;
   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   typedef enum logic [2:0] {
      IDLE, FETCH, FWAIT, EXEC1, EXEC2, EXEC3, MWAIT
   } state_t;

   typedef enum logic [2:0] {
      OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_LD, OP_ST, OP_MVNZ, OP_AND
   } op_t;

   state_t            state, state_nx;
   logic [DATA_W-1:0] r [NREG];
   logic [DATA_W-1:0] a, g, rx, ry, alu;
   logic [IW-1:0]     ir;
   op_t               op;
   logic [RSEL_W-1:0] x, y;
   logic              cout;
   logic              abort;
   logic              blocked;

   if (DATA_W < IW) begin : g_chk_iw
      $error("param_proc: DATA_W too small for the instruction word");
   end
   if (ADDR_W > DATA_W) begin : g_chk_aw
      $error("param_proc: ADDR_W must not exceed DATA_W");
   end
   if (TIMEOUT < 1) begin : g_chk_to
      $error("param_proc: TIMEOUT must be at least 1");
   end

   assign op = op_t'(ir[IW-1 -: 3]);
   assign x  = ir[2*RSEL_W-1 -: RSEL_W];
   assign y  = ir[RSEL_W-1:0];
   assign rx = r[x];
   assign ry = r[y];

`ifdef PARAM_PROC_WAIT_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wcnt;
   logic          fault_q;

   assign abort   = MemReq && !MemReady && (wcnt == CW'(TIMEOUT - 1));
   assign blocked = fault_q;
   assign Fault   = fault_q;

   // count consecutive not-ready cycles of a pending access; latch fault on expiry
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         wcnt    <= '0;
         fault_q <= 1'b0;
      end else begin
         if (MemReq && !MemReady) wcnt <= wcnt + CW'(1);
         else                     wcnt <= '0;
         if (abort) fault_q <= 1'b1;
      end
   end
`else
   assign abort   = 1'b0;
   assign blocked = 1'b0;
   assign Fault   = 1'b0;
`endif

   // ALU: result and carry/borrow for the EXEC2 step
   always_comb begin
      alu  = '0;
      cout = 1'b0;
      unique case (op)
         OP_ADD: {cout, alu} = {1'b0, a} + {1'b0, ry};
         OP_SUB: begin
            alu  = a - ry;
            cout = (a < ry);
         end
         default: alu = a & ry;
      endcase
   end

   // state register
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // next state and state-decoded memory/Done strobes
   always_comb begin
      state_nx = state;
      MemReq   = 1'b0;
      W        = 1'b0;
      Done     = 1'b0;
      unique case (state)
         IDLE:  if (Run && !blocked) state_nx = FETCH;
         FETCH: state_nx = FWAIT;
         FWAIT: begin
            MemReq = 1'b1;
            if (abort)         state_nx = IDLE;
            else if (MemReady) state_nx = EXEC1;
         end
         EXEC1: begin
            unique case (op)
               OP_MV, OP_MVNZ:      Done = 1'b1;
               OP_MVI, OP_LD, OP_ST: state_nx = MWAIT;
               default:             state_nx = EXEC2;
            endcase
         end
         EXEC2: state_nx = EXEC3;
         EXEC3: Done = 1'b1;
         MWAIT: begin
            MemReq = 1'b1;
            W      = (op == OP_ST);
            if (abort)         state_nx = IDLE;
            else if (MemReady) Done = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
      if (Done) state_nx = Run ? FETCH : IDLE;
   end

   // datapath: register file, IR, A/G, address/data and flags
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < NREG; i++) r[i] <= '0;
         a     <= '0;
         g     <= '0;
         ir    <= '0;
         ADDR  <= '0;
         DOUT  <= '0;
         Zero  <= 1'b0;
         Carry <= 1'b0;
      end else begin
         unique case (state)
            FETCH: ADDR <= r[PC][ADDR_W-1:0];
            FWAIT: begin
               if (MemReady) begin
                  ir    <= DIN[IW-1:0];
                  r[PC] <= r[PC] + ONE;
               end
            end
            EXEC1: begin
               unique case (op)
                  OP_MV:   r[x] <= ry;
                  OP_MVNZ: if (!Zero) r[x] <= ry;
                  OP_MVI:  ADDR <= r[PC][ADDR_W-1:0];
                  OP_LD:   ADDR <= ry[ADDR_W-1:0];
                  OP_ST: begin
                     ADDR <= ry[ADDR_W-1:0];
                     DOUT <= rx;
                  end
                  default: a <= rx;
               endcase
            end
            EXEC2: begin
               g     <= alu;
               Zero  <= (alu == '0);
               Carry <= cout;
            end
            EXEC3: r[x] <= g;
            MWAIT: begin
               if (MemReady) begin
                  unique case (op)
                     OP_LD: r[x] <= DIN;
                     OP_MVI: begin
                        r[PC] <= r[PC] + ONE;
                        r[x]  <= DIN;
                     end
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_param_proc.sv
// tb_param_proc: random programs run in lockstep with an ISA-level model.
// Covers async reset mid-store and, with PARAM_PROC_WAIT_TIMEOUT_EN, the timeout fault.
module tb_param_proc;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int RW = 3;
   localparam int N  = 1500;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          run;
   logic [DW-1:0] din;
   logic          mem_ready;
   logic          mem_req, w, done, zero, carry, fault;
   logic [AW-1:0] addr;
   logic [DW-1:0] dout;

   always #5 clk = ~clk;

   param_proc #(
      .DATA_W(DW), .ADDR_W(AW), .RSEL_W(RW), .TIMEOUT(16)
   ) dut (
      .Clock(clk), .Resetn(rst_n), .Run(run), .DIN(din),
      .MemReady(mem_ready), .MemReq(mem_req), .W(w), .ADDR(addr),
      .DOUT(dout), .Done(done), .Zero(zero), .Carry(carry), .Fault(fault)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // memory seen by the DUT, and the model's own copy
   logic [15:0] mem   [65536];
   logic [15:0] m_mem [65536];
   logic [15:0] m_r   [8];
   logic        m_z, m_c;

   logic [2:0]  cur_op;
   logic        is_mem;
   logic [15:0] exp_daddr, exp_sdata, exp_pc;

   // ISA-level execution of one instruction (PC already points past it)
   task automatic m_exec(input logic [15:0] iw);
      logic [2:0]  x, y;
      int unsigned sum;
      logic [15:0] v;
      cur_op = iw[8:6];
      x      = iw[5:3];
      y      = iw[2:0];
      is_mem = (cur_op == 3'd1) || (cur_op == 3'd4) || (cur_op == 3'd5);
      m_r[7] = m_r[7] + 16'd1;
      case (cur_op)
         3'd0: m_r[x] = m_r[y];
         3'd1: begin
            exp_daddr = m_r[7];
            v         = m_mem[exp_daddr];
            m_r[7]    = m_r[7] + 16'd1;
            m_r[x]    = v;
         end
         3'd2: begin
            sum    = int'(m_r[x]) + int'(m_r[y]);
            m_c    = (sum > 65535);
            v      = 16'(sum % 65536);
            m_r[x] = v;
            m_z    = (v == 0);
         end
         3'd3: begin
            m_c    = (m_r[x] < m_r[y]);
            v      = m_r[x] - m_r[y];
            m_r[x] = v;
            m_z    = (v == 0);
         end
         3'd4: begin
            exp_daddr = m_r[y];
            m_r[x]    = m_mem[exp_daddr];
         end
         3'd5: begin
            exp_daddr        = m_r[y];
            exp_sdata        = m_r[x];
            m_mem[exp_daddr] = m_r[x];
         end
         3'd6: if (!m_z) m_r[x] = m_r[y];
         default: begin
            v      = m_r[x] & m_r[y];
            m_r[x] = v;
            m_z    = (v == 0);
            m_c    = 1'b0;
         end
      endcase
   endtask

   int cyc, start, n_done, idle_left, acc_wait, acc_k, kf, km, exp_lat, phase;
   bit hung;

   initial begin
      // ---- reset values and async reset during a store wait ----
      rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; din = '0;
      repeat (2) @(negedge clk);
      check("rst_req", mem_req, 1'b0);
      check("rst_w", w, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_zero", zero, 1'b0);
      check("rst_carry", carry, 1'b0);
      check("rst_fault", fault, 1'b0);
      check("rst_addr", addr, 16'h0);
      check("rst_dout", dout, 16'h0);
      rst_n = 1'b1;
      @(negedge clk); run = 1'b1;
      @(negedge clk); #1 check("r_fetch_req", mem_req, 1'b0);
      @(negedge clk); din = 16'h0178; mem_ready = 1'b1;
      #1 check("r_fwait_req", mem_req, 1'b1);
      check("r_fwait_addr", addr, 16'h0);
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk); #1;
      check("r_st_req", mem_req, 1'b1);
      check("r_st_w", w, 1'b1);
      check("r_st_dout", dout, 16'h0001);
      #2 rst_n = 1'b0;
      #1;
      check("r_async_req", mem_req, 1'b0);
      check("r_async_w", w, 1'b0);
      check("r_async_done", done, 1'b0);
      check("r_async_dout", dout, 16'h0);
      run = 1'b0;
      @(negedge clk);

      // ---- program: directed prologue, random memory elsewhere ----
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[0]  = 16'h0040; mem[1]  = 16'hFFFF;
      mem[2]  = 16'h0048; mem[3]  = 16'h0001;
      mem[4]  = 16'h0081; mem[5]  = 16'h0193;
      mem[6]  = 16'h0048; mem[7]  = 16'hABCD;
      mem[8]  = 16'h0050; mem[9]  = 16'h0010;
      mem[10] = 16'h014A; mem[11] = 16'h0122;
      mem[12] = 16'h0040; mem[13] = 16'h0020;
      mem[14] = 16'h0038;
      for (int i = 0; i < 65536; i++) m_mem[i] = mem[i];
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      m_z = 1'b0; m_c = 1'b0;

      // ---- lockstep run ----
      @(negedge clk);
      rst_n = 1'b1; run = 1'b1;
      cyc = 0; start = 0; n_done = 0; idle_left = 0;
      acc_wait = -1; acc_k = 0; kf = 0; km = 0; phase = 0; hung = 1'b0;
      while (n_done < N && !hung && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         if (mem_req) begin
            if (acc_wait < 0) begin
               acc_k    = $urandom_range(0, 3);
               acc_wait = 0;
            end
            mem_ready = (acc_wait == acc_k);
            din       = mem[addr];
            if (mem_ready && w) mem[addr] = dout;
            acc_wait++;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
            din       = 16'($urandom);
            acc_wait  = -1;
         end
         #1;
         if (idle_left > 0) begin
            check("idle_req", mem_req, 1'b0);
            check("idle_done", done, 1'b0);
            idle_left--;
            if (idle_left == 0) begin
               run   = 1'b1;
               start = cyc;
            end
         end else begin
            if (mem_req) begin
               if (phase == 0) begin
                  if (acc_wait == 1) begin
                     exp_pc = m_r[7];
                     m_exec(m_mem[m_r[7]]);
                     kf = acc_k;
                     if (n_done == N - 1 || $urandom_range(0, 5) == 0)
                        run = 1'b0;
                  end
                  check("fetch_addr", addr, exp_pc);
                  check("fetch_w", w, 1'b0);
                  if (mem_ready) phase = 1;
               end else if (!is_mem) begin
                  check("extra_req", mem_req, 1'b0);
               end else begin
                  check("data_addr", addr, exp_daddr);
                  check("data_w", w, cur_op == 3'd5);
                  if (cur_op == 3'd5) check("st_dout", dout, exp_sdata);
                  km = acc_k;
               end
            end
            if (done) begin
               n_done++;
               if (cur_op == 3'd0 || cur_op == 3'd6) exp_lat = 3 + kf;
               else if (is_mem)                      exp_lat = 4 + kf + km;
               else                                  exp_lat = 5 + kf;
               check("latency", cyc - start, exp_lat);
               check("zero", zero, m_z);
               check("carry", carry, m_c);
               check("fault", fault, 1'b0);
               phase = 0;
               start = cyc;
               if (!run && n_done < N) idle_left = $urandom_range(1, 3);
            end else if (cyc - start > 40) begin
               check("done_timeout", done, 1'b1);
               hung = 1'b1;
            end
         end
      end
      check("instr_count", n_done, N);

`ifdef PARAM_PROC_WAIT_TIMEOUT_EN
      // ---- memory never ready: fault after 16 wait cycles ----
      @(negedge clk); mem_ready = 1'b0; run = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); #1;
         check("to_wait_req", mem_req, 1'b1);
         check("to_no_fault", fault, 1'b0);
         check("to_no_done", done, 1'b0);
      end
      @(negedge clk); #1;
      check("to_fault", fault, 1'b1);
      check("to_idle_req", mem_req, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check("to_run_ignored", mem_req, 1'b0);
         check("to_sticky", fault, 1'b1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/param_proc.md
# param_proc

Parametrised multicycle processor core: a generalised successor to the team's fixed 16-bit, 8-register, 9-bit-instruction processor. Data width and register-file size are parameters, and memory access uses a ready/request handshake with arbitrary wait states. The ISA adds a logical AND and Zero/Carry flags. The core sits between the top-level Run/Done control and a shared instruction/data memory port.

## Interface
Parameters:
- DATA_W, 16, width of registers, bus, DIN and DOUT; must satisfy DATA_W >= 3 + 2*RSEL_W
- ADDR_W, 16, memory address width; ADDR = low ADDR_W bits of the source register; ADDR_W <= DATA_W
- RSEL_W, 3, register-select field width; NREG = 2^RSEL_W; R[NREG-1] is the PC
- TIMEOUT, 16, maximum wait cycles per memory access; used only when PARAM_PROC_WAIT_TIMEOUT_EN is defined

Ports:
- Clock  in  1  single clock; all state updates on its rising edge
- Resetn  in  1  reset, asynchronous, active-low
- Run  in  1  start and continue execution
- DIN  in  DATA_W  memory read data; valid in a cycle where MemReq=1 and MemReady=1
- MemReady  in  1  memory completes the current access
- MemReq  out  1  memory access pending
- W  out  1  write strobe; qualifies MemReq for stores
- ADDR  out  ADDR_W  memory address register
- DOUT  out  DATA_W  store data register
- Done  out  1  one-cycle pulse in the final cycle of each instruction
- Zero  out  1  flag: last ALU result == 0
- Carry  out  1  flag: carry-out on add; borrow on sub
- Fault  out  1  sticky memory-timeout fault; tied 0 unless the macro is defined

## Operation
- Instruction encoding: IW = 3 + 2*RSEL_W bits, taken from DIN[IW-1:0]. Fields from MSB: opcode[2:0], X[RSEL_W-1:0], Y[RSEL_W-1:0].
- Opcodes:
  - 000 mv: Rx <= Ry
  - 001 mvi: Rx <= next memory word; PC skips that word
  - 010 add: Rx <= Rx + Ry
  - 011 sub: Rx <= Rx - Ry
  - 100 ld: Rx <= mem[Ry]
  - 101 st: mem[Ry] <= Rx
  - 110 mvnz: if Zero==0 then Rx <= Ry
  - 111 and: Rx <= Rx & Ry
- FSM states: IDLE, FETCH, FWAIT, EXEC1, EXEC2, EXEC3, MWAIT.
  - IDLE: if Run, go to FETCH.
  - FETCH: ADDR <= PC; go to FWAIT.
  - FWAIT: MemReq=1, W=0. On MemReady: IR <= DIN[IW-1:0], PC <= PC+1, go to EXEC1.
  - EXEC1:
    - mv: write Rx, Done.
    - mvnz: conditional write, Done.
    - mvi: ADDR <= PC, go to MWAIT.
    - ld: ADDR <= Ry, go to MWAIT.
    - st: ADDR <= Ry, DOUT <= Rx, go to MWAIT.
    - add/sub/and: A <= Rx, go to EXEC2.
  - EXEC2: G <= A op Ry; Zero and Carry update; go to EXEC3.
  - EXEC3: Rx <= G, Done.
  - MWAIT: MemReq=1, W=1 only for st. On MemReady:
    - ld: Rx <= DIN, Done.
    - mvi: Rx <= DIN, PC <= PC+1, Done.
    - st: Done.
- After Done: go to FETCH if Run=1, else IDLE.
- Run falling mid-instruction: the current instruction completes, then the FSM enters IDLE.
- Arithmetic: modulo 2^DATA_W.
  - add: Carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - sub: Carry = 1 when Rx < Ry (unsigned).
  - and: Carry = 0.
  - Flags change only in EXEC2.
- PC as destination (X = NREG-1): the explicit write wins over any increment in the same cycle, so mv/ld to the PC is a jump. mvi into the PC loads DIN; no increment.
- PC wraps from 2^DATA_W-1 to 0.
- MemReady is ignored while MemReq=0.

## Timing
- Reset (asynchronous, Resetn=0): state IDLE. All registers, A, G, IR, ADDR, DOUT are 0. MemReq, W, Done, Zero, Carry, Fault are all 0.
- Reset mid-access drops MemReq and W immediately, without waiting for a clock edge.
- MemReq, W and Done are decoded from state, so they are valid in the same cycle as the state.
- Cycle counts, Run to Done, with k = wait cycles per access (k=0 means MemReady high on first MemReq cycle):
  - mv/mvnz: 3+k
  - ld/st/mvi: 4+2k
  - add/sub/and: 5+k
- Back-to-back instructions: FETCH follows the Done cycle directly.
- Memory port: ADDR and DOUT are stable throughout MemReq. A store completes in the cycle where MemReq=W=MemReady=1.

## Configuration
- PARAM_PROC_WAIT_TIMEOUT_EN defined:
  - A wait counter runs in FWAIT and MWAIT.
  - When MemReady has stayed low for TIMEOUT consecutive cycles, the access is abandoned: no register write, no Done, Fault <= 1 (sticky until reset), state -> IDLE.
  - While Fault=1, IDLE ignores Run.
- Not defined: no counter; FWAIT and MWAIT wait indefinitely; Fault is constant 0.

## Test plan
All scenarios use DATA_W=16 and RSEL_W=3.
- Reset: assert Resetn=0 mid-MWAIT of a st -> MemReq, W and Done drop immediately; PC=0 and all outputs 0; after release with Run=1, first ADDR=0.
- mvi R0 with memory {0:0x040, 1:0x0005} and MemReady delayed 2 cycles per access -> MemReq held until ready; R0=5, PC=2; one Done pulse 8 cycles after Run.
- add R0,R1 with R0=0xFFFF, R1=0x0001 -> R0=0, Zero=1, Carry=1, Done at cycle 5. Then mvnz R2,R3 -> R2 unchanged.
- st R1,R2 with R1=0xABCD, R2=0x0010 -> ADDR=0x0010, DOUT=0xABCD, W=1 with MemReq until MemReady. Then ld R4,R2 returning 0xABCD -> R4=0xABCD.
- mv R7,R0 with R0=0x0020 -> next FETCH drives ADDR=0x0020; no increment applied. Run=0 during that instruction -> FSM enters IDLE after Done.
- With PARAM_PROC_WAIT_TIMEOUT_EN and TIMEOUT=16, MemReady held 0 -> Fault=1 after 16 FWAIT cycles, no Done, IDLE; Run=1 ignored until reset.
